// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the N-channel memory-bus arbiter.
package mem_arbiter_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   localparam int unsigned ARB_FIXED = 0;
   localparam int unsigned ARB_RR    = 1;

   // Increment a channel index modulo n.
   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
      return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester (H-side) and memory (P-side) bus bundle of the memory arbiter.
interface mem_arbiter_if #(
   parameter int unsigned N_CH = 2,
   parameter int unsigned AW   = 64,
   parameter int unsigned DW   = 64
);
   logic [N_CH-1:0]    HTRANS;
   logic [N_CH-1:0]    HWRITE;
   logic [N_CH*AW-1:0] HADDR;
   logic [N_CH*DW-1:0] HWDATA;
   logic [N_CH-1:0]    HREADY;
   logic [N_CH-1:0]    HERR;
   logic [DW-1:0]      HRDATA;
   logic [N_CH-1:0]    STALL;
   logic               PSEL;
   logic               PWRITE;
   logic [AW-1:0]      PADDR;
   logic [DW-1:0]      PDATA;
   logic [DW-1:0]      PRDATA;
   logic               PREADY;

   modport slave (
      input  HTRANS, HWRITE, HADDR, HWDATA, PRDATA, PREADY,
      output HREADY, HERR, HRDATA, STALL, PSEL, PWRITE, PADDR, PDATA
   );

   modport master (
      output HTRANS, HWRITE, HADDR, HWDATA, PRDATA, PREADY,
      input  HREADY, HERR, HRDATA, STALL, PSEL, PWRITE, PADDR, PDATA
   );
endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational request picker: rotate the doubled request vector by the start
// pointer, take the lowest set bit, and map it back to a channel index.
module mem_arbiter_rr_pick #(
   parameter int unsigned N_CH = 2
) (
   input  logic [N_CH-1:0]         req,
   input  logic [$clog2(N_CH)-1:0] ptr,
   input  logic                    mode,
   output logic [N_CH-1:0]         grant_oh,
   output logic [$clog2(N_CH)-1:0] grant_idx
);
   localparam int unsigned IW = $clog2(N_CH);

   logic [IW-1:0]   start;
   logic [N_CH-1:0] rot;
   logic [IW-1:0]   off;
   logic            hit;
   int unsigned     sum;

   always_comb begin
      start = mode ? ptr : '0;
      rot   = N_CH'({req, req} >> start);
      off   = '0;
      hit   = 1'b0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (rot[i]) begin
            off = IW'(i);
            hit = 1'b1;
         end
      end
      sum       = 32'(off) + 32'(start);
      grant_idx = IW'((sum >= N_CH) ? sum - N_CH : sum);
      grant_oh  = hit ? (N_CH'(1) << grant_idx) : '0;
   end

endmodule

// File: rtl/mem_arbiter.sv
// N-channel memory-bus arbiter: fixed-priority or round-robin grant, P-bus latch,
// PREADY wait states and a per-transaction timeout that aborts with HERR.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned N_CH     = 2,
   parameter int unsigned AW       = 64,
   parameter int unsigned DW       = 64,
   parameter int unsigned ARB_MODE = 0,
   parameter int unsigned TIMEOUT  = 255,
   parameter int unsigned TO_W     = 8
) (
   input logic           CLK,
   input logic           RESET,
   mem_arbiter_if.slave  bus
);
   localparam int unsigned IW = $clog2(N_CH);

   state_e          state_q, state_d;
   logic [IW-1:0]   grant_q, grant_d;
   logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [TO_W-1:0] cnt_q, cnt_d;
   logic            psel_q, psel_d;
   logic            pwrite_q, pwrite_d;
   logic [AW-1:0]   paddr_q, paddr_d;
   logic [DW-1:0]   pdata_q, pdata_d;

   logic [IW-1:0]   ptr_next, arb_ptr, pick_idx;
   logic [N_CH-1:0] grant_oh, arb_req, pick_oh;
   logic [N_CH-1:0] hready_c, herr_c;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_data;
   logic            sel_write;
   logic            busy, pick_any, done_c, tmo_c, load;

   assign busy     = (state_q == ST_BUSY);
   assign grant_oh = N_CH'(1) << grant_q;
   assign ptr_next = IW'(wrap_inc(32'(grant_q), N_CH));
   assign done_c   = busy & bus.PREADY & ~RESET;
   assign tmo_c    = busy & ~bus.PREADY & ~RESET & (TIMEOUT != 0)
                     & (cnt_q == TO_W'(TIMEOUT - 1));

   // On completion the finishing channel still shows HTRANS for the old request, so skip it
   assign arb_req  = bus.HTRANS & ~(busy ? grant_oh : '0);
   assign arb_ptr  = busy ? ptr_next : rr_ptr_q;
   assign pick_any = |pick_oh;
   assign load     = pick_any & (~busy | done_c);

   mem_arbiter_rr_pick #(.N_CH(N_CH)) u_pick (
      .req       (arb_req),
      .ptr       (arb_ptr),
      .mode      (ARB_MODE == ARB_RR),
      .grant_oh  (pick_oh),
      .grant_idx (pick_idx)
   );

   // AND-OR select of the winning channel's request fields
   always_comb begin
      sel_addr  = '0;
      sel_data  = '0;
      sel_write = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         if (pick_oh[i]) begin
            sel_addr  = sel_addr | bus.HADDR[i*AW +: AW];
            sel_data  = sel_data | bus.HWDATA[i*DW +: DW];
            sel_write = sel_write | bus.HWRITE[i];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (pick_any) state_d = ST_BUSY;
         ST_BUSY: begin
            if (done_c)     state_d = pick_any ? ST_BUSY : ST_IDLE;
            else if (tmo_c) state_d = ST_IDLE;
         end
      endcase
   end

   // Grant, pointer, timeout counter and P-bus next values
   always_comb begin
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      cnt_d    = cnt_q;
      psel_d   = psel_q;
      pwrite_d = pwrite_q;
      paddr_d  = paddr_q;
      pdata_d  = pdata_q;
      if (busy & ~bus.PREADY) cnt_d = cnt_q + TO_W'(1);
      if (done_c | tmo_c) begin
         rr_ptr_d = ptr_next;
         psel_d   = 1'b0;
      end
      if (load) begin
         grant_d  = pick_idx;
         cnt_d    = '0;
         psel_d   = 1'b1;
         pwrite_d = sel_write;
         paddr_d  = sel_addr;
         pdata_d  = sel_data;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         grant_q  <= '0;
         rr_ptr_q <= '0;
         cnt_q    <= '0;
         psel_q   <= 1'b0;
         pwrite_q <= 1'b0;
         paddr_q  <= '0;
         pdata_q  <= '0;
      end else begin
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
         cnt_q    <= cnt_d;
         psel_q   <= psel_d;
         pwrite_q <= pwrite_d;
         paddr_q  <= paddr_d;
         pdata_q  <= pdata_d;
      end
   end

   assign hready_c   = done_c ? grant_oh : '0;
   assign herr_c     = tmo_c ? grant_oh : '0;
   assign bus.HREADY = hready_c;
   assign bus.HERR   = herr_c;
   assign bus.HRDATA = bus.PRDATA;
   assign bus.STALL  = bus.HTRANS & ~hready_c & ~herr_c;
   assign bus.PSEL   = psel_q;
   assign bus.PWRITE = pwrite_q;
   assign bus.PADDR  = paddr_q;
   assign bus.PDATA  = pdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a 2-channel fixed-priority instance (TIMEOUT=4) and a
// 4-channel round-robin instance (TIMEOUT=6) checked against a transaction model.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int unsigned TO_B   = 6;
   localparam int unsigned MODE_B = 1;

   logic clk = 1'b0;
   logic rst_a, rst_b;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   mem_arbiter_if #(.N_CH(2), .AW(64), .DW(64)) ia ();
   mem_arbiter_if #(.N_CH(4), .AW(64), .DW(64)) ib ();

   mem_arbiter #(.N_CH(2), .AW(64), .DW(64), .ARB_MODE(0), .TIMEOUT(4), .TO_W(8)) dut_a (
      .CLK(clk), .RESET(rst_a), .bus(ia));
   mem_arbiter #(.N_CH(4), .AW(64), .DW(64), .ARB_MODE(1), .TIMEOUT(TO_B), .TO_W(8)) dut_b (
      .CLK(clk), .RESET(rst_b), .bus(ib));

   typedef struct {
      logic        rst;
      logic [1:0]  htrans;
      logic        pready;
      logic [63:0] a0, a1;
      logic        psel, pwrite;
      logic [63:0] paddr;
      logic [1:0]  hready, herr, stall;
   } vec_t;

   vec_t tbl[12];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step_a(input logic r, input logic [1:0] ht, input logic [1:0] hw,
                         input logic pr, input logic [63:0] prd,
                         input logic [63:0] a0, input logic [63:0] a1);
      @(posedge clk); #1;
      rst_a      = r;
      ia.HTRANS  = ht;
      ia.HWRITE  = hw;
      ia.PREADY  = pr;
      ia.PRDATA  = prd;
      ia.HADDR   = {a1, a0};
      ia.HWDATA  = {~a1, ~a0};
      @(negedge clk);
   endtask

   function automatic int pick(input logic [3:0] req, input int start);
      for (int k = 0; k < 4; k++) begin
         if (req[(start + k) % 4]) return (start + k) % 4;
      end
      return -1;
   endfunction

   // Transaction-level reference state for the random run on dut_b
   int          owner, wait_n, ptr, c;
   logic [63:0] m_addr, m_data, prd;
   logic        m_write, pr;
   logic [3:0]  pend, hw, exp_rdy, exp_err;
   logic [255:0] haddr_v, hwdata_v;

   initial begin
      rst_a = 1'b1; rst_b = 1'b1;
      ia.HTRANS = '0; ia.HWRITE = '0; ia.HADDR = '0; ia.HWDATA = '0;
      ia.PREADY = 1'b0; ia.PRDATA = '0;
      ib.HTRANS = '0; ib.HWRITE = '0; ib.HADDR = '0; ib.HWDATA = '0;
      ib.PREADY = 1'b0; ib.PRDATA = '0;

      // rst htrans pr a0 a1 | psel pwrite paddr hready herr stall
      tbl[0]  = '{1'b1, 2'b11, 1'b1, 64'h100, 64'h1000, 1'b0, 1'b0, 64'h0,    2'b00, 2'b00, 2'b11};
      tbl[1]  = '{1'b1, 2'b11, 1'b1, 64'h100, 64'h1000, 1'b0, 1'b0, 64'h0,    2'b00, 2'b00, 2'b11};
      tbl[2]  = '{1'b0, 2'b11, 1'b1, 64'h100, 64'h1000, 1'b0, 1'b0, 64'h0,    2'b00, 2'b00, 2'b11};
      tbl[3]  = '{1'b0, 2'b11, 1'b1, 64'h100, 64'h1000, 1'b1, 1'b0, 64'h100,  2'b01, 2'b00, 2'b10};
      tbl[4]  = '{1'b0, 2'b11, 1'b1, 64'h200, 64'h1000, 1'b1, 1'b1, 64'h1000, 2'b10, 2'b00, 2'b01};
      tbl[5]  = '{1'b0, 2'b01, 1'b1, 64'h200, 64'h1000, 1'b1, 1'b0, 64'h200,  2'b01, 2'b00, 2'b00};
      tbl[6]  = '{1'b0, 2'b00, 1'b0, 64'h200, 64'h1000, 1'b0, 1'b0, 64'h200,  2'b00, 2'b00, 2'b00};
      tbl[7]  = '{1'b0, 2'b10, 1'b0, 64'h200, 64'h1000, 1'b0, 1'b0, 64'h200,  2'b00, 2'b00, 2'b10};
      tbl[8]  = '{1'b0, 2'b11, 1'b0, 64'h300, 64'h1234, 1'b1, 1'b1, 64'h1000, 2'b00, 2'b00, 2'b11};
      tbl[9]  = '{1'b0, 2'b11, 1'b1, 64'h300, 64'h1234, 1'b1, 1'b1, 64'h1000, 2'b10, 2'b00, 2'b01};
      tbl[10] = '{1'b0, 2'b01, 1'b1, 64'h300, 64'h1234, 1'b1, 1'b0, 64'h300,  2'b01, 2'b00, 2'b00};
      tbl[11] = '{1'b0, 2'b00, 1'b0, 64'h300, 64'h1234, 1'b0, 1'b0, 64'h300,  2'b00, 2'b00, 2'b00};

      for (int v = 0; v < 12; v++) begin
         step_a(tbl[v].rst, tbl[v].htrans, 2'b10, tbl[v].pready, 64'h0, tbl[v].a0, tbl[v].a1);
         chk($sformatf("tbl%0d_psel", v),   64'(ia.PSEL),   64'(tbl[v].psel));
         chk($sformatf("tbl%0d_pwrite", v), 64'(ia.PWRITE), 64'(tbl[v].pwrite));
         chk($sformatf("tbl%0d_paddr", v),  ia.PADDR,       tbl[v].paddr);
         chk($sformatf("tbl%0d_hready", v), 64'(ia.HREADY), 64'(tbl[v].hready));
         chk($sformatf("tbl%0d_herr", v),   64'(ia.HERR),   64'(tbl[v].herr));
         chk($sformatf("tbl%0d_stall", v),  64'(ia.STALL),  64'(tbl[v].stall));
      end

      // Read on ch1 with three wait states; completion coincides with the timeout count
      step_a(1'b0, 2'b10, 2'b00, 1'b0, 64'h0, 64'h0, 64'h80);
      chk("rd_idle_psel", 64'(ia.PSEL), 64'd0);
      for (int k = 1; k <= 3; k++) begin
         step_a(1'b0, 2'b10, 2'b00, 1'b0, 64'h0, 64'h0, 64'h80);
         chk($sformatf("rd_wait%0d_hready", k), 64'(ia.HREADY), 64'd0);
         chk($sformatf("rd_wait%0d_paddr", k),  ia.PADDR,       64'h80);
      end
      step_a(1'b0, 2'b10, 2'b00, 1'b1, 64'hDEAD_BEEF, 64'h0, 64'h80);
      chk("rd_hready", 64'(ia.HREADY), 64'h2);
      chk("rd_herr",   64'(ia.HERR),   64'h0);
      chk("rd_hrdata", ia.HRDATA,      64'hDEAD_BEEF);
      chk("rd_pwrite", 64'(ia.PWRITE), 64'h0);
      step_a(1'b0, 2'b00, 2'b00, 1'b0, 64'h0, 64'h0, 64'h80);
      chk("rd_end_psel", 64'(ia.PSEL), 64'd0);

      // Timeout abort on ch0 after four BUSY cycles without PREADY
      step_a(1'b0, 2'b01, 2'b00, 1'b0, 64'h0, 64'h40, 64'h0);
      for (int k = 1; k <= 4; k++) begin
         step_a(1'b0, 2'b01, 2'b00, 1'b0, 64'h0, 64'h40, 64'h0);
         chk($sformatf("to_cyc%0d_herr", k),   64'(ia.HERR),   (k == 4) ? 64'h1 : 64'h0);
         chk($sformatf("to_cyc%0d_hready", k), 64'(ia.HREADY), 64'h0);
      end
      chk("to_stall", 64'(ia.STALL), 64'h0);
      step_a(1'b0, 2'b00, 2'b00, 1'b0, 64'h0, 64'h40, 64'h0);
      chk("to_after_herr",  64'(ia.HERR), 64'h0);
      chk("to_after_psel",  64'(ia.PSEL), 64'h0);

      // Reset in the second BUSY cycle while PREADY rises
      step_a(1'b0, 2'b01, 2'b00, 1'b0, 64'h0, 64'h44, 64'h0);
      step_a(1'b0, 2'b01, 2'b00, 1'b0, 64'h0, 64'h44, 64'h0);
      chk("rst_busy_psel", 64'(ia.PSEL), 64'h1);
      step_a(1'b1, 2'b01, 2'b00, 1'b1, 64'h0, 64'h44, 64'h0);
      chk("rst_hready", 64'(ia.HREADY), 64'h0);
      chk("rst_herr",   64'(ia.HERR),   64'h0);
      step_a(1'b0, 2'b00, 2'b00, 1'b0, 64'h0, 64'h44, 64'h0);
      chk("rst_after_psel",  64'(ia.PSEL),  64'h0);
      chk("rst_after_paddr", ia.PADDR,      64'h0);

      // Round-robin with all four channels requesting and PREADY high
      @(posedge clk); #1;
      rst_b = 1'b0;
      ib.HTRANS = 4'b1111; ib.PREADY = 1'b1;
      for (int i = 0; i < 4; i++) ib.HADDR[i*64 +: 64] = 64'(16 * (i + 1));
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk($sformatf("rr%0d_hready", k), 64'(ib.HREADY), 64'(4'b0001 << (k % 4)));
         chk($sformatf("rr%0d_paddr", k),  ib.PADDR,       64'(16 * ((k % 4) + 1)));
      end

      // Random traffic against the transaction model
      @(posedge clk); #1;
      rst_b = 1'b1; ib.HTRANS = '0; ib.PREADY = 1'b0;
      owner = -1; wait_n = 0; ptr = 0; pend = '0;
      m_addr = '0; m_data = '0; m_write = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(posedge clk); #1;
         rst_b = 1'b0;
         for (int i = 0; i < 4; i++) begin
            if (!pend[i] && ($urandom_range(0, 1) == 1)) pend[i] = 1'b1;
            haddr_v[i*64 +: 64]  = {$urandom, $urandom};
            hwdata_v[i*64 +: 64] = {$urandom, $urandom};
            hw[i] = 1'($urandom_range(0, 1));
         end
         pr  = ($urandom_range(0, 9) < 3);
         prd = {$urandom, $urandom};
         ib.HTRANS = pend; ib.HWRITE = hw; ib.HADDR = haddr_v; ib.HWDATA = hwdata_v;
         ib.PREADY = pr;   ib.PRDATA = prd;
         @(negedge clk);

         exp_rdy = '0; exp_err = '0;
         if (owner >= 0) begin
            if (pr) exp_rdy[owner] = 1'b1;
            else if (wait_n == TO_B - 1) exp_err[owner] = 1'b1;
         end
         chk("rnd_hready", 64'(ib.HREADY), 64'(exp_rdy));
         chk("rnd_herr",   64'(ib.HERR),   64'(exp_err));
         chk("rnd_stall",  64'(ib.STALL),  64'(pend & ~exp_rdy & ~exp_err));
         chk("rnd_psel",   64'(ib.PSEL),   64'(owner >= 0));
         if (owner >= 0) begin
            chk("rnd_paddr",  ib.PADDR,       m_addr);
            chk("rnd_pdata",  ib.PDATA,       m_data);
            chk("rnd_pwrite", 64'(ib.PWRITE), 64'(m_write));
         end
         if (exp_rdy != 0) chk("rnd_hrdata", ib.HRDATA, prd);

         c = -1;
         if (owner < 0) begin
            c = pick(pend, (MODE_B == 1) ? ptr : 0);
         end else if (pr) begin
            ptr   = (owner + 1) % 4;
            c     = pick(pend & ~(4'b0001 << owner), (MODE_B == 1) ? ptr : 0);
            owner = -1;
         end else if (exp_err != 0) begin
            ptr   = (owner + 1) % 4;
            owner = -1;
         end else begin
            wait_n++;
         end
         if (c >= 0) begin
            owner   = c;
            wait_n  = 0;
            m_addr  = haddr_v[c*64 +: 64];
            m_data  = hwdata_v[c*64 +: 64];
            m_write = hw[c];
         end
         pend = pend & ~(exp_rdy | exp_err);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
